// File: rtl/ula_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Registers the winner's operands, then captures the opcode-qualified ALU result one cycle later.
module ula_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_stat,
  output logic             busy,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_tula,
  input  logic [WIDTH-1:0] ula_outp,
  input  logic             ula_stat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_winner;
  logic   w_any;
  logic   w_arb;
  logic   w_grant;
  logic   w_pick1;
  logic   w_is_cmp;

  // Tie goes to the requester that did not win last time.
  assign w_any   = req0 | req1;
  assign w_arb   = (r_state != EXEC);
  assign w_grant = w_arb & w_any;
  assign w_pick1 = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE:    w_next = w_any ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Compares leave outp stale and arithmetic ops leave stat stale.
  always_comb begin
    w_is_cmp = 1'b0;
    case (ula_tula)
      3'b011, 3'b100, 3'b101: w_is_cmp = 1'b1;
      default:                w_is_cmp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_winner <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      res      <= '0;
      res_stat <= 1'b0;
      ula_a    <= '0;
      ula_b    <= '0;
      ula_tula <= 3'b000;
    end else begin
      gnt0  <= w_grant & ~w_pick1;
      gnt1  <= w_grant & w_pick1;
      done0 <= (r_state == EXEC) & ~r_winner;
      done1 <= (r_state == EXEC) & r_winner;
      busy  <= (w_next != IDLE);
      if (w_grant) begin
        r_winner <= w_pick1;
        r_last   <= w_pick1;
        ula_tula <= w_pick1 ? op1 : op0;
        ula_a    <= w_pick1 ? a1 : a0;
        ula_b    <= w_pick1 ? b1 : b0;
      end
      if (r_state == EXEC) begin
        if (w_is_cmp) begin
          res      <= '0;
          res_stat <= ula_stat;
        end else begin
          res      <= ula_outp;
          res_stat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: emulated ALU, transaction-level reference model, directed and random scenarios.
module tb_ula_arbiter;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [2:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, res_stat, busy, ula_stat;
  logic [W-1:0] res, ula_a, ula_b, ula_outp;
  logic [2:0]   ula_tula;

  int n_checks = 0;
  int n_errors = 0;

  ula_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .res_stat(res_stat), .busy(busy),
    .ula_a(ula_a), .ula_b(ula_b), .ula_tula(ula_tula),
    .ula_outp(ula_outp), .ula_stat(ula_stat)
  );

  always #5 clk = ~clk;

  // Full ALU behaviour: {data result, compare result}.
  function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] v;
    logic       s;
    v = 4'd0;
    s = 1'b0;
    case (op)
      3'd0: v = 4'(a + b);
      3'd1: v = 4'(a - b);
      3'd2: v = 4'(4'd0 - b);
      3'd3: s = (a == b);
      3'd4: s = (a > b);
      3'd5: s = (a < b);
      3'd6: v = a & b;
      default: v = a ^ b;
    endcase
    return {v, s};
  endfunction

  function automatic logic is_cmp(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

  // ALU stand-in: the output it does not update carries junk.
  logic [3:0] junk_o = '0;
  logic       junk_s = 1'b0;
  logic [4:0] alu_full;
  always @(negedge clk) begin
    junk_o <= 4'($urandom);
    junk_s <= 1'($urandom);
  end
  always_comb begin
    alu_full = ref_alu(ula_tula, ula_a, ula_b);
    ula_outp = is_cmp(ula_tula) ? junk_o : alu_full[4:1];
    ula_stat = is_cmp(ula_tula) ? alu_full[0] : junk_s;
  end

  // Transaction model: an op is issued at one edge and finishes at the next; issue only when nothing is in flight.
  logic       m_last = 1'b1, m_id = 1'b0, m_inflight = 1'b0;
  logic [1:0] e_gnt = '0, e_done = '0;
  logic       e_busy = 1'b0, e_stat = 1'b0;
  logic [3:0] e_res = '0, e_a = '0, e_b = '0;
  logic [2:0] e_op = '0;
  logic       n_fire, n_id;
  logic [4:0] fin;
  always_comb begin
    n_fire = !m_inflight && (req0 || req1);
    n_id   = (req0 && req1) ? !m_last : req1;
    fin    = ref_alu(e_op, e_a, e_b);
  end
  always @(posedge clk) begin
    if (rst) begin
      m_last <= 1'b1; m_id <= 1'b0; m_inflight <= 1'b0;
      e_gnt <= '0; e_done <= '0; e_busy <= 1'b0;
      e_res <= '0; e_stat <= 1'b0; e_a <= '0; e_b <= '0; e_op <= '0;
    end else begin
      e_gnt  <= n_fire ? (n_id ? 2'b10 : 2'b01) : 2'b00;
      e_done <= m_inflight ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      e_busy <= n_fire || m_inflight;
      if (m_inflight) begin
        e_res  <= is_cmp(e_op) ? 4'd0 : fin[4:1];
        e_stat <= is_cmp(e_op) ? fin[0] : 1'b0;
      end
      if (n_fire) begin
        m_last <= n_id;
        m_id   <= n_id;
        e_op   <= n_id ? op1 : op0;
        e_a    <= n_id ? a1 : a0;
        e_b    <= n_id ? b1 : b0;
      end
      m_inflight <= n_fire;
    end
  end

  logic [20:0] dut_vec, exp_vec;
  assign dut_vec = {gnt0, gnt1, done0, done1, busy, res, res_stat, ula_a, ula_b, ula_tula};
  assign exp_vec = {e_gnt[0], e_gnt[1], e_done[0], e_done[1], e_busy, e_res, e_stat, e_a, e_b, e_op};

  task automatic set0(input logic r, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    req0 = r; op0 = o; a0 = a; b0 = b;
  endtask

  task automatic set1(input logic r, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    req1 = r; op1 = o; a1 = a; b1 = b;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 21'd0) begin n_errors++; $display("FAIL reset_held got=%h want=0", dut_vec); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 21'd0) begin n_errors++; $display("FAIL reset_idle%0d got=%h want=0", i, dut_vec); end
    end
  endtask

  task automatic test_add_wrap();
    set0(1'b1, 3'd0, 4'd9, 4'd8);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, busy, ula_tula, ula_a, ula_b} !== {1'b1, 1'b0, 1'b1, 3'd0, 4'd9, 4'd8}) begin
      n_errors++; $display("FAIL add_gnt got=%b want=%b", {gnt0, gnt1, busy, ula_tula, ula_a, ula_b}, {1'b1, 1'b0, 1'b1, 3'd0, 4'd9, 4'd8});
    end
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if ({gnt0, done0, done1, res, res_stat} !== {1'b0, 1'b1, 1'b0, 4'd1, 1'b0}) begin
      n_errors++; $display("FAIL add_done got=%b want=%b", {gnt0, done0, done1, res, res_stat}, {1'b0, 1'b1, 1'b0, 4'd1, 1'b0});
    end
    @(negedge clk);
    n_checks++;
    if ({done0, busy, res} !== {1'b0, 1'b0, 4'd1}) begin
      n_errors++; $display("FAIL add_after got=%b want=%b", {done0, busy, res}, {1'b0, 1'b0, 4'd1});
    end
  endtask

  task automatic test_compare();
    logic [2:0] ops [3];
    logic [3:0] as  [3];
    logic [3:0] bs  [3];
    logic       st  [3];
    ops = '{3'd4, 3'd3, 3'd5};
    as  = '{4'd5, 4'd4, 4'd4};
    bs  = '{4'd3, 4'd4, 4'd4};
    st  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      set1(1'b1, ops[i], as[i], bs[i]);
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1} !== 2'b01) begin n_errors++; $display("FAIL cmp%0d_gnt got=%b want=01", i, {gnt0, gnt1}); end
      set1(1'b0, 3'd0, 4'd0, 4'd0);
      @(negedge clk);
      n_checks++;
      if ({done0, done1, res, res_stat} !== {1'b0, 1'b1, 4'd0, st[i]}) begin
        n_errors++; $display("FAIL cmp%0d_done got=%b want=%b", i, {done0, done1, res, res_stat}, {1'b0, 1'b1, 4'd0, st[i]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    set0(1'b1, 3'd6, 4'hC, 4'hA);
    set1(1'b1, 3'd7, 4'hC, 4'hA);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== {k % 4 == 1, k % 4 == 3, k % 4 == 2, k % 4 == 0, 1'b1}) begin
        n_errors++; $display("FAIL b2b_c%0d got=%b want=%b", k, {gnt0, gnt1, done0, done1, busy},
                             {k % 4 == 1, k % 4 == 3, k % 4 == 2, k % 4 == 0, 1'b1});
      end
      if (k % 4 == 2 || k % 4 == 0) begin
        n_checks++;
        if (res !== ((k % 4 == 2) ? 4'd8 : 4'd6)) begin
          n_errors++; $display("FAIL b2b_res%0d got=%h want=%h", k, res, (k % 4 == 2) ? 4'd8 : 4'd6);
        end
      end
    end
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    set1(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin n_errors++; $display("FAIL b2b_idle got=%b want=000", {gnt0, gnt1, busy}); end
  endtask

  task automatic test_fairness();
    set1(1'b1, 3'd7, 4'd1, 4'd2);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin n_errors++; $display("FAIL fair_gnt1 got=%b want=01", {gnt0, gnt1}); end
    set0(1'b1, 3'd2, 4'd5, 4'd3);
    set1(1'b1, 3'd0, 4'd6, 4'd6);
    @(negedge clk);
    n_checks++;
    if ({done1, res} !== {1'b1, 4'd3}) begin n_errors++; $display("FAIL fair_done1 got=%b want=%b", {done1, res}, {1'b1, 4'd3}); end
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, ula_tula, ula_a, ula_b} !== {1'b1, 1'b0, 3'd2, 4'd5, 4'd3}) begin
      n_errors++; $display("FAIL fair_gnt0 got=%b want=%b", {gnt0, gnt1, ula_tula, ula_a, ula_b}, {1'b1, 1'b0, 3'd2, 4'd5, 4'd3});
    end
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    set1(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if ({done0, res, res_stat} !== {1'b1, 4'hD, 1'b0}) begin
      n_errors++; $display("FAIL neg_done got=%b want=%b", {done0, res, res_stat}, {1'b1, 4'hD, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set0(1'b1, 3'd1, 4'd7, 4'd2);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL rmid_gnt got=%b want=1", gnt0); end
    rst = 1'b1;
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 21'd0) begin n_errors++; $display("FAIL rmid_zero got=%h want=0", dut_vec); end
    rst = 1'b0;
    set0(1'b1, 3'd0, 4'd1, 4'd1);
    set1(1'b1, 3'd0, 4'd2, 4'd2);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, ula_a} !== {1'b1, 1'b0, 4'd1}) begin
      n_errors++; $display("FAIL rmid_tie got=%b want=%b", {gnt0, gnt1, ula_a}, {1'b1, 1'b0, 4'd1});
    end
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    set1(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if ({done0, res} !== {1'b1, 4'd2}) begin n_errors++; $display("FAIL rmid_done got=%b want=%b", {done0, res}, {1'b1, 4'd2}); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_errors++; $display("FAIL rand_c%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      // Keep an ungranted request stable; otherwise pick fresh stimulus.
      if (rst || !req0 || e_gnt[0])
        set0(1'($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), 4'($urandom));
      if (rst || !req1 || e_gnt[1])
        set1(1'($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), 4'($urandom));
      rst = ($urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    set0(1'b0, 3'd0, 4'd0, 4'd0);
    set1(1'b0, 3'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_compare();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
